vga_scan_ctrl: RTL and testbench
================================

VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 SHALL have parameters: H_ACTIVE 1440, H_FP 80, H_SYNC 152, H_BP 232 (H_TOTAL 1904), all in pixels.
REQ-002 SHALL have parameters: V_ACTIVE 900, V_FP 1, V_SYNC 3, V_BP 28 (V_TOTAL 932), all in lines.
REQ-003 SHALL have parameters: HSYNC_POL 0 (active-low), VSYNC_POL 1 (active-high), COLOR_W 4, DRAW_LAT 1 (renderer latency in enabled cycles, legal range 0..4).
REQ-004 SHALL have ports, clock and reset first:
  clk  in  1  single system clock, all logic on the rising edge
  rst  in  1  synchronous, active-high reset
  ce  in  1  pixel enable; state advances only when high
  draw_r/draw_g/draw_b  in  COLOR_W each  renderer colour for the pixel requested DRAW_LAT enabled cycles earlier
  curr_x  out  X_W = clog2(H_TOTAL)  current horizontal count
  curr_y  out  Y_W = clog2(V_TOTAL)  current vertical count
  req_valid  out  1  (curr_x, curr_y) lies in the active area
  frame_start  out  1  high while counters = (0,0)
  line_start  out  1  high while horizontal count = 0
  hsync/vsync  out  1  sync outputs at the configured polarity
  de  out  1  aligned display enable
  pix_r/pix_g/pix_b  out  COLOR_W each  blanked, aligned pixel colour
REQ-005 SHALL reject illegal parameters at elaboration: any timing value of 0, or DRAW_LAT outside 0..4.

Function
REQ-006 SHALL count horizontally 0..H_TOTAL-1, then wrap to 0 and increment the vertical count, only on cycles with ce=1.
REQ-007 SHALL count vertically 0..V_TOTAL-1; on a simultaneous horizontal and vertical wrap, both counters SHALL go to 0.
REQ-008 SHALL lay out each line as: active at h < H_ACTIVE, then front porch, then sync at H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, then back porch; vertical layout SHALL be the same form using the V_* parameters.
REQ-009 SHALL drive curr_x, curr_y, req_valid, frame_start and line_start combinationally from the counters; this is stage 0, and the renderer latency is measured from it.
REQ-010 SHALL define stage-0 raw signals as hs0 = h in sync region, vs0 = v in sync region, de0 = h < H_ACTIVE and v < V_ACTIVE.
REQ-011 SHALL delay hs0/vs0/de0 through a DRAW_LAT-deep enabled pipeline and then one output register, so total latency is L = DRAW_LAT+1 enabled cycles.
REQ-012 SHALL register pix_* as draw_* when the delayed de is 1, and 0 otherwise, in the same enabled cycle as the final sync/de register.
REQ-013 SHALL present hsync = HSYNC_POL when delayed hs=1, else ~HSYNC_POL; vsync SHALL follow the same rule with VSYNC_POL.
REQ-014 SHALL, when ce=0, hold all counters, pipeline stages and outputs unchanged; stage-0 combinational outputs SHALL follow the held counters.
REQ-015 SHALL give rst priority over ce.

Reset
REQ-016 SHALL, on the edge where rst=1, set counters to 0 and clear every pipeline stage to the inactive state (hs=0, vs=0, de=0).
REQ-017 SHALL hold these output values after reset: hsync = ~HSYNC_POL, vsync = ~VSYNC_POL, de 0, pix_* 0, curr_x 0, curr_y 0, req_valid 1, frame_start 1, line_start 1.
REQ-018 SHALL, if rst is asserted mid-frame, restart the frame at (0,0) on the next cycle with no partial-line output; the first valid de SHALL appear L enabled cycles after rst is released.

Structure
REQ-019 SHALL take from a shared package vga_timing_pkg: the default 1440x900 timing constants, a total-count function, and the polarity constants.
REQ-020 SHALL implement the alignment pipeline as one sub-module, vga_delay_line: parametrised width and depth (depth 0 = wire), with ce and synchronous reset; it SHALL be instantiated once for {hs, vs, de}.

Verification
Bench parameters: H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), DRAW_LAT 2, ce tied to 1 unless stated.
REQ-021 SHALL cover free-run over 3 frames: de high for exactly 32 cycles per frame; hsync low for cycles h=10..12 shifted by 3; vsync high for lines 5..6 shifted by 3; frame period 128 cycles.
REQ-022 SHALL cover alignment: renderer model returns draw_r = curr_x, delayed 2 cycles -> pix_r equals x for x = 0..7 in the same cycle de=1, and 0 during blanking.
REQ-023 SHALL cover wrap: at counters (15,7), the next cycle is (0,0) with frame_start=1 and line_start=1; at (15,3) the next cycle is (0,4).
REQ-024 SHALL cover ce gating: ce held at 0 for 5 cycles at (3,1) -> counters and all outputs frozen; on resume, the sequence continues from (4,1) with nothing dropped.
REQ-025 SHALL cover mid-frame reset: rst pulsed at (6,2) -> next cycle counters (0,0), de 0, pix 0; first de=1 occurs 3 cycles after rst falls.
REQ-026 SHALL cover defaults: with the default parameters, the hsync low period is 152 cycles, the line is 1904 cycles, the frame is 932 lines, and each frame has 1440x900 de-high cycles.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, polarity constants and helpers for the
// scan controller and its alignment pipeline.
package vga_timing_pkg;

  // Default 1440x900 timing, horizontal in pixels, vertical in lines.
  localparam int DEF_H_ACTIVE = 1440;
  localparam int DEF_H_FP     = 80;
  localparam int DEF_H_SYNC   = 152;
  localparam int DEF_H_BP     = 232;
  localparam int DEF_V_ACTIVE = 900;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 28;

  localparam int DEF_COLOR_W  = 4;
  localparam int DEF_DRAW_LAT = 1;
  localparam int MAX_DRAW_LAT = 4;

  localparam logic POL_LOW  = 1'b0;
  localparam logic POL_HIGH = 1'b1;

  // Raw timing flags carried together through the alignment pipeline.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  function automatic int total_count(input int active, input int fp,
                                     input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enabled shift register with synchronous clear; depth 0 is a wire.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (ce) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA raster counters with renderer request outputs and a latency-matched
// sync/de/colour output stage.
module vga_scan_ctrl
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE  = DEF_H_ACTIVE,
  parameter int   H_FP      = DEF_H_FP,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BP      = DEF_H_BP,
  parameter int   V_ACTIVE  = DEF_V_ACTIVE,
  parameter int   V_FP      = DEF_V_FP,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BP      = DEF_V_BP,
  parameter logic HSYNC_POL = POL_LOW,
  parameter logic VSYNC_POL = POL_HIGH,
  parameter int   COLOR_W   = DEF_COLOR_W,
  parameter int   DRAW_LAT  = DEF_DRAW_LAT,
  localparam int  H_TOTAL   = total_count(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int  V_TOTAL   = total_count(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int  X_W       = $clog2(H_TOTAL),
  localparam int  Y_W       = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic [COLOR_W-1:0] draw_r,
  input  logic [COLOR_W-1:0] draw_g,
  input  logic [COLOR_W-1:0] draw_b,
  output logic [X_W-1:0]     curr_x,
  output logic [Y_W-1:0]     curr_y,
  output logic               req_valid,
  output logic               frame_start,
  output logic               line_start,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] pix_r,
  output logic [COLOR_W-1:0] pix_g,
  output logic [COLOR_W-1:0] pix_b
);

  if ((H_ACTIVE <= 0) || (H_FP <= 0) || (H_SYNC <= 0) || (H_BP <= 0) ||
      (V_ACTIVE <= 0) || (V_FP <= 0) || (V_SYNC <= 0) || (V_BP <= 0)) begin : g_bad_timing
    $error("vga_scan_ctrl: every timing parameter must be non-zero");
  end
  if ((DRAW_LAT < 0) || (DRAW_LAT > MAX_DRAW_LAT)) begin : g_bad_lat
    $error("vga_scan_ctrl: DRAW_LAT must lie in 0..4");
  end

  localparam logic [X_W-1:0] H_LAST     = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_ACT_END  = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] H_SYNC_BEG = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] H_SYNC_END = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0] V_LAST     = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_ACT_END  = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] V_SYNC_BEG = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] V_SYNC_END = Y_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [X_W-1:0] h_cnt;
  logic [Y_W-1:0] v_cnt;
  sync_t          raw;
  sync_t          dly;
  sync_t          out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + Y_W'(1);
      end else begin
        h_cnt <= h_cnt + X_W'(1);
      end
    end
  end

  // Stage 0. req_valid is a qualifier with no ready: the renderer must
  // answer every enabled cycle, DRAW_LAT enabled cycles later.
  always_comb begin
    raw    = '0;
    raw.hs = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    raw.vs = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
    raw.de = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  end

  assign curr_x      = h_cnt;
  assign curr_y      = v_cnt;
  assign req_valid   = raw.de;
  assign line_start  = (h_cnt == '0);
  assign frame_start = (h_cnt == '0) && (v_cnt == '0);

  vga_delay_line #(
    .WIDTH ($bits(sync_t)),
    .DEPTH (DRAW_LAT)
  ) u_align (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .d   (raw),
    .q   (dly)
  );

  // Final register: colour is captured in the same enabled cycle as the
  // delayed de, so blanking never leaks renderer data.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      pix_r <= '0;
      pix_g <= '0;
      pix_b <= '0;
    end else if (ce) begin
      out_q <= dly;
      pix_r <= dly.de ? draw_r : '0;
      pix_g <= dly.de ? draw_g : '0;
      pix_b <= dly.de ? draw_b : '0;
    end
  end

  assign hsync = out_q.hs ? HSYNC_POL : ~HSYNC_POL;
  assign vsync = out_q.vs ? VSYNC_POL : ~VSYNC_POL;
  assign de    = out_q.de;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: small-timing instance against a position-based
// reference model, plus a default-timing instance for line-level checks.
module tb_vga_scan_ctrl;

  localparam int HT    = 16;
  localparam int LAT   = 3;
  localparam int FRAME = 128;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce  = 1'b0;
  logic [3:0] draw_r = '0, draw_g = '0, draw_b = '0;
  logic [3:0] curr_x;
  logic [2:0] curr_y;
  logic       req_valid, frame_start, line_start, hsync, vsync, de;
  logic [3:0] pix_r, pix_g, pix_b;

  logic [10:0] d_x;
  logic [9:0]  d_y;
  logic        d_req_valid, d_frame_start, d_line_start, d_hsync, d_vsync, d_de;
  logic [3:0]  d_pix_r, d_pix_g, d_pix_b;

  always #5 clk = ~clk;

  vga_scan_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .COLOR_W(4), .DRAW_LAT(2)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .draw_r(draw_r), .draw_g(draw_g), .draw_b(draw_b),
    .curr_x(curr_x), .curr_y(curr_y), .req_valid(req_valid),
    .frame_start(frame_start), .line_start(line_start),
    .hsync(hsync), .vsync(vsync), .de(de),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b)
  );

  vga_scan_ctrl dut_def (
    .clk(clk), .rst(rst), .ce(1'b1),
    .draw_r(4'h0), .draw_g(4'h0), .draw_b(4'h0),
    .curr_x(d_x), .curr_y(d_y), .req_valid(d_req_valid),
    .frame_start(d_frame_start), .line_start(d_line_start),
    .hsync(d_hsync), .vsync(d_vsync), .de(d_de),
    .pix_r(d_pix_r), .pix_g(d_pix_g), .pix_b(d_pix_b)
  );

  int total = 0;
  int bad   = 0;
  int n     = 0;        // enabled cycles since reset = stage-0 raster index
  int bq[$];            // random blue value requested at each raster index

  typedef struct {
    logic [3:0] x;
    logic [2:0] y;
    logic [3:0] b;
  } req_t;
  req_t rq[$];

  // ---------------- reference model (raster position arithmetic) -------
  function automatic int opos(input int k);
    if (k < LAT) return -1;
    return (k - LAT) % FRAME;
  endfunction

  function automatic logic m_de(input int p);
    return (p >= 0) && (p % HT < 8) && (p / HT < 4);
  endfunction

  function automatic logic [24:0] exp_vec(input int k);
    int s, p;
    logic [3:0] er, eg, eb;
    s  = k % FRAME;
    p  = opos(k);
    er = m_de(p) ? 4'(p % HT) : 4'h0;
    eg = m_de(p) ? 4'(p / HT) : 4'h0;
    eb = m_de(p) ? 4'(bq[k-LAT]) : 4'h0;
    return {4'(s % HT), 3'(s / HT),
            (s % HT < 8) && (s / HT < 4), s == 0, s % HT == 0,
            !((p >= 0) && (p % HT >= 10) && (p % HT < 13)),
            (p >= 0) && (p / HT >= 5) && (p / HT < 7),
            m_de(p), er, eg, eb};
  endfunction

  function automatic logic [24:0] dut_vec();
    return {curr_x, curr_y, req_valid, frame_start, line_start,
            hsync, vsync, de, pix_r, pix_g, pix_b};
  endfunction

  // ---------------- driver: one clock, renderer answers with 2-cycle lag -
  task automatic step(input logic ce_v, input logic rst_v);
    req_t r;
    ce  = ce_v;
    rst = rst_v;
    if (ce_v && !rst_v) begin
      r.x = curr_x;
      r.y = curr_y;
      r.b = 4'($urandom_range(0, 15));
      rq.push_back(r);
      bq.push_back(int'(r.b));
      if (rq.size() > 3) void'(rq.pop_front());
      if (rq.size() == 3) begin
        draw_r = rq[0].x;
        draw_g = {1'b0, rq[0].y};
        draw_b = rq[0].b;
      end else begin
        draw_r = '0; draw_g = '0; draw_b = '0;
      end
    end
    @(posedge clk);
    #1;
    if (rst_v) begin
      n = 0;
      rq.delete();
      bq.delete();
    end else if (ce_v) begin
      n++;
    end
  endtask

  task automatic advance_to(input int target);
    int guard;
    guard = 0;
    while ((n % FRAME != target) && (guard < 400)) begin
      step(1'b1, 1'b0);
      guard++;
    end
    total++;
    if (n % FRAME != target) begin
      bad++;
      $display("FAIL advance_to: raster index %0d, required %0d", n % FRAME, target);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    step(1'b0, 1'b1);
    rst = 1'b0;
    total++; if (curr_x !== 4'd0)  begin bad++; $display("FAIL reset_curr_x: got %0d want 0", curr_x); end
    total++; if (curr_y !== 3'd0)  begin bad++; $display("FAIL reset_curr_y: got %0d want 0", curr_y); end
    total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL reset_req_valid: got %b want 1", req_valid); end
    total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL reset_frame_start: got %b want 1", frame_start); end
    total++; if (line_start !== 1'b1) begin bad++; $display("FAIL reset_line_start: got %b want 1", line_start); end
    total++; if (hsync !== 1'b1)   begin bad++; $display("FAIL reset_hsync: got %b want 1", hsync); end
    total++; if (vsync !== 1'b0)   begin bad++; $display("FAIL reset_vsync: got %b want 0", vsync); end
    total++; if (de !== 1'b0)      begin bad++; $display("FAIL reset_de: got %b want 0", de); end
    total++; if ({pix_r, pix_g, pix_b} !== 12'h000) begin bad++; $display("FAIL reset_pix: got %h want 000", {pix_r, pix_g, pix_b}); end
    total++; if (d_hsync !== 1'b1 || d_vsync !== 1'b0 || d_de !== 1'b0) begin
      bad++; $display("FAIL reset_default_sync: got hs=%b vs=%b de=%b want 1 0 0", d_hsync, d_vsync, d_de);
    end
  endtask

  task automatic test_defaults();
    int tf1, tr1, tf2, dr1, df1, dr2;
    logic phs, pde;
    tf1 = -1; tr1 = -1; tf2 = -1; dr1 = -1; df1 = -1; dr2 = -1;
    phs = d_hsync; pde = d_de;
    for (int i = 0; i < 4000 && tf2 < 0; i++) begin
      step(1'b1, 1'b0);
      if (phs && !d_hsync) begin if (tf1 < 0) tf1 = n; else if (tf2 < 0) tf2 = n; end
      if (!phs && d_hsync && tr1 < 0) tr1 = n;
      if (!pde && d_de) begin if (dr1 < 0) dr1 = n; else if (dr2 < 0) dr2 = n; end
      if (pde && !d_de && df1 < 0) df1 = n;
      phs = d_hsync; pde = d_de;
    end
    total++; if (dr1 != 2)          begin bad++; $display("FAIL def_first_de: got %0d want 2", dr1); end
    total++; if (tr1 - tf1 != 152)  begin bad++; $display("FAIL def_hsync_low: got %0d want 152", tr1 - tf1); end
    total++; if (tf2 - tf1 != 1904) begin bad++; $display("FAIL def_line_hsync: got %0d want 1904", tf2 - tf1); end
    total++; if (df1 - dr1 != 1440) begin bad++; $display("FAIL def_de_run: got %0d want 1440", df1 - dr1); end
    total++; if (dr2 - dr1 != 1904) begin bad++; $display("FAIL def_line_de: got %0d want 1904", dr2 - dr1); end
  endtask

  task automatic test_free_run();
    int de_f[3];
    int hs_low, vs_high, fs_cnt, p;
    logic [24:0] e;
    step(1'b0, 1'b1);
    hs_low = 0; vs_high = 0; fs_cnt = 0;
    for (int f = 0; f < 3; f++) de_f[f] = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step(1'b1, 1'b0);
      e = exp_vec(n);
      total++;
      if (dut_vec() !== e) begin bad++; $display("FAIL free_run n=%0d: got %h want %h", n, dut_vec(), e); end
      p = n - LAT;
      if (de === 1'b1 && p >= 0) de_f[(p / FRAME) % 3]++;
      if (hsync === 1'b0) hs_low++;
      if (vsync === 1'b1) vs_high++;
      if (frame_start === 1'b1) fs_cnt++;
    end
    for (int f = 0; f < 3; f++) begin
      total++; if (de_f[f] != 32) begin bad++; $display("FAIL free_run_de_count frame %0d: got %0d want 32", f, de_f[f]); end
    end
    total++; if (hs_low != 72)  begin bad++; $display("FAIL free_run_hsync_low: got %0d want 72", hs_low); end
    total++; if (vs_high != 96) begin bad++; $display("FAIL free_run_vsync_high: got %0d want 96", vs_high); end
    total++; if (fs_cnt != 3)   begin bad++; $display("FAIL free_run_frame_starts: got %0d want 3", fs_cnt); end
  endtask

  task automatic test_alignment();
    int p;
    step(1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0);
      p = opos(n);
      total++;
      if (m_de(p)) begin
        if (de !== 1'b1 || pix_r !== 4'(p % HT) || pix_g !== 4'(p / HT)) begin
          bad++; $display("FAIL align n=%0d: got de=%b r=%0d g=%0d want de=1 r=%0d g=%0d",
                          n, de, pix_r, pix_g, p % HT, p / HT);
        end
      end else if (de !== 1'b0 || {pix_r, pix_g, pix_b} !== 12'h000) begin
        bad++; $display("FAIL align_blank n=%0d: got de=%b pix=%h want 0 000", n, de, {pix_r, pix_g, pix_b});
      end
    end
  endtask

  task automatic test_wrap();
    advance_to(127);
    total++; if ({curr_x, curr_y} !== {4'd15, 3'd7}) begin bad++; $display("FAIL wrap_pre_frame: got (%0d,%0d) want (15,7)", curr_x, curr_y); end
    step(1'b1, 1'b0);
    total++;
    if ({curr_x, curr_y, frame_start, line_start} !== {4'd0, 3'd0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL wrap_frame: got (%0d,%0d) fs=%b ls=%b want (0,0) 1 1", curr_x, curr_y, frame_start, line_start);
    end
    advance_to(63);
    step(1'b1, 1'b0);
    total++;
    if ({curr_x, curr_y, frame_start, line_start} !== {4'd0, 3'd4, 1'b0, 1'b1}) begin
      bad++; $display("FAIL wrap_line: got (%0d,%0d) fs=%b ls=%b want (0,4) 0 1", curr_x, curr_y, frame_start, line_start);
    end
  endtask

  task automatic test_ce_gate();
    logic [24:0] e;
    advance_to(19);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      e = exp_vec(n);
      total++;
      if (dut_vec() !== e) begin bad++; $display("FAIL ce_hold cycle %0d: got %h want %h", i, dut_vec(), e); end
    end
    step(1'b1, 1'b0);
    total++; if ({curr_x, curr_y} !== {4'd4, 3'd1}) begin bad++; $display("FAIL ce_resume: got (%0d,%0d) want (4,1)", curr_x, curr_y); end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0);
      e = exp_vec(n);
      total++;
      if (dut_vec() !== e) begin bad++; $display("FAIL ce_after n=%0d: got %h want %h", n, dut_vec(), e); end
    end
  endtask

  task automatic test_mid_reset();
    int cnt;
    advance_to(38);
    step(1'b1, 1'b1);
    total++;
    if ({curr_x, curr_y, de, pix_r, pix_g, pix_b} !== 20'h0) begin
      bad++; $display("FAIL mid_reset: got x=%0d y=%0d de=%b pix=%h want 0 0 0 000", curr_x, curr_y, de, {pix_r, pix_g, pix_b});
    end
    cnt = 0;
    while (de !== 1'b1 && cnt < 10) begin
      step(1'b1, 1'b0);
      cnt++;
    end
    total++; if (cnt != 3) begin bad++; $display("FAIL mid_reset_latency: got %0d want 3", cnt); end
  endtask

  task automatic test_random_ce();
    logic [24:0] e;
    for (int i = 0; i < 700; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'b0);
      e = exp_vec(n);
      total++;
      if (dut_vec() !== e) begin bad++; $display("FAIL random_ce n=%0d: got %h want %h", n, dut_vec(), e); end
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_free_run();
    test_alignment();
    test_wrap();
    test_ce_gate();
    test_mid_reset();
    test_random_ce();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
